gray_ptr_ctrl: RTL
==================

Name: gray_ptr_ctrl

Overview:
- Parametrised pointer controller for one side of the async FIFO.
- Keeps the local pointer in binary and Gray form and advances it on accepted push/pop.
- Converts the already-synchronised remote Gray pointer to binary, with an optional register stage.
- Produces registered fill level, full/empty, almost flags and a sticky misuse error; the write or read role is selected by parameter.

Parameters:
- ADDR_W, 4, address width; FIFO depth DEPTH = 2^ADDR_W; pointers are ADDR_W+1 bits.
- IS_WR, 1, 1 = write side (flag means full), 0 = read side (flag means empty).
- CONV_PIPE, 1, 0 = combinational remote Gray-to-binary; 1 = one register stage after conversion.
- ALMOST_TH, 2, almost threshold: WR asserts when level >= DEPTH-ALMOST_TH; RD asserts when level <= ALMOST_TH.

Ports:
- clk  in  1  local domain clock
- rst_n  in  1  asynchronous, active-low reset
- inc  in  1  push (WR) or pop (RD) request
- remote_gray  in  ADDR_W+1  opposite-side Gray pointer, already synchronised into clk
- err_clr  in  1  clears sticky err
- accept  out  1  combinational: inc & ~flag
- ptr_bin  out  ADDR_W+1  local binary pointer, registered
- ptr_gray  out  ADDR_W+1  local Gray pointer, registered; goes to the opposite synchroniser
- addr  out  ADDR_W  ptr_bin[ADDR_W-1:0], RAM address
- level  out  ADDR_W+1  registered occupancy, 0..DEPTH
- flag  out  1  registered full (WR) / empty (RD)
- almost  out  1  registered almost-full / almost-empty
- err  out  1  sticky misuse/corruption error

Behaviour:
- Reset (async assert, sync release):
  - ptr_bin = 0, ptr_gray = 0, remote pipe register = 0.
  - level = 0, err = 0.
  - flag = 0 for WR, 1 for RD.
  - almost = 0 for WR, 1 for RD.
- Pointer update:
  - bin_next = ptr_bin + accept, modulo 2^(ADDR_W+1); wraps from all-ones to 0.
  - gray_next = bin_next ^ (bin_next >> 1).
  - Both register on every clk edge.
  - ptr_gray changes by exactly one bit per accepted op and never more.
- Remote conversion:
  - rbin[k] = XOR of remote_gray bits k..ADDR_W.
  - CONV_PIPE=1 adds one register, making flags one cycle more pessimistic. This is legal and required; the local side never over-runs.
- Level (registered, computed from bin_next and rbin):
  - WR: diff = bin_next - rbin (mod 2^(ADDR_W+1)).
  - RD: diff = rbin - bin_next.
  - If diff <= DEPTH, level = diff.
  - Otherwise level clamps to DEPTH (WR) or 0 (RD), and err sets (pointer corruption).
- Flags:
  - WR: flag = (level_next == DEPTH).
  - RD: flag = (level_next == 0).
  - A local op and a remote pointer move in the same cycle both take effect in the next level; no priority is needed.
  - flag falls only after the remote pointer has been converted: latency = 1 + CONV_PIPE cycles from the remote_gray change.
  - flag rises in the cycle after the last accepted op (zero added latency).
- Misuse:
  - inc while flag = 1: not accepted, pointer held, err sets.
  - err holds until err_clr.
  - err_clr and a new error in the same cycle: set wins.
- Reset mid-operation: all state returns to reset values immediately; the opposite side must be reset together.
- No state machine beyond the pointer, pipe and error registers. Target 150-250 lines.

Decomposition:
- Package gray_fifo_pkg:
  - function bin_to_gray(width-generic).
  - function gray_to_bin(prefix XOR).
  - constants for the WR/RD role encoding.
- One sub-module, gray_to_bin_stage (parameters W and REG):
  - Combinational converter plus optional output register.
  - Instantiated once for remote_gray.

Test Plan (ADDR_W=3, DEPTH=8, ALMOST_TH=2):
1. Reset, IS_WR=1, remote_gray=0 -> ptr_bin=0, level=0, flag=0, almost=0. With IS_WR=0 -> flag=1, almost=1.
2. WR, remote fixed 0, inc held 10 cycles -> 8 accepts, level climbs 1..8, almost high from level 6, flag high the cycle after the 8th accept. inc at cycle 9 -> accept=0, ptr_bin stays 8, err=1.
3. WR full, then remote_gray steps 0000→0001 (rbin=1) -> with CONV_PIPE=1 flag drops and level=7 two cycles later; with CONV_PIPE=0, one cycle later.
4. Wrap: run 20 accept/remote-advance pairs -> ptr_bin wraps 1111→0000 and ptr_gray 1000→0000. Every successive ptr_gray differs by exactly one bit, and level stays constant.
5. RD, remote_gray = bin_to_gray(5) -> level=5, flag=0. Pop 5 times -> level 0, flag=1, almost high from level 2. err_clr pulsed the same cycle as a 6th pop -> err=1 (set wins).
6. Corruption: WR, ptr_bin=2, remote rbin=12 (diff 6 mod 16 ok), then rbin=11 (diff 7) -> normal. Then rbin=1 with ptr_bin=12 (diff 11 > 8) -> level=8, flag=1, err=1.

Source files
------------

// File: rtl/gray_fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion and role encoding.
package gray_fifo_pkg;

  // Helpers operate on a fixed maximum width; callers zero-extend in and truncate out.
  localparam int unsigned GW = 32;

  localparam bit ROLE_WR = 1'b1;
  localparam bit ROLE_RD = 1'b0;

  function automatic logic [GW-1:0] bin_to_gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave narrower values intact.
  function automatic logic [GW-1:0] gray_to_bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin_stage.sv
// Gray-to-binary converter with an optional output register stage.
module gray_to_bin_stage
  import gray_fifo_pkg::*;
#(
  parameter int unsigned W   = 5,
  parameter bit          REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic [W-1:0] conv;

  assign conv = W'(gray_to_bin(GW'(gray)));

  generate
    if (REG) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bin <= '0;
        end else begin
          bin <= conv;
        end
      end
    end else begin : g_comb
      assign bin = conv;
    end
  endgenerate

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an async FIFO: local binary/Gray pointer, remote pointer conversion,
// registered occupancy, full/empty and almost flags, and a sticky misuse error.
module gray_ptr_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter bit          IS_WR     = ROLE_WR,
  parameter bit          CONV_PIPE = 1'b1,
  parameter int unsigned ALMOST_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic [ADDR_W:0]   remote_gray,
  input  logic              err_clr,
  output logic              accept,
  output logic [ADDR_W:0]   ptr_bin,
  output logic [ADDR_W:0]   ptr_gray,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   level,
  output logic              flag,
  output logic              almost,
  output logic              err
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [PW-1:0] rbin;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] diff;
  logic [PW-1:0] level_next;
  logic          corrupt;
  logic          flag_next;
  logic          almost_next;
  logic          err_next;

  gray_to_bin_stage #(
    .W   (PW),
    .REG (CONV_PIPE)
  ) u_rconv (
    .clk   (clk),
    .rst_n (rst_n),
    .gray  (remote_gray),
    .bin   (rbin)
  );

  assign addr = ptr_bin[ADDR_W-1:0];

  // Next pointer, occupancy and flags; a local op and a remote move combine without priority.
  always_comb begin
    accept      = inc & ~flag;
    bin_next    = ptr_bin + PW'(accept);
    gray_next   = PW'(bin_to_gray(GW'(bin_next)));
    diff        = (IS_WR == ROLE_WR) ? (bin_next - rbin) : (rbin - bin_next);
    corrupt     = diff > PW'(DEPTH);
    level_next  = diff;
    if (corrupt) begin
      level_next = (IS_WR == ROLE_WR) ? PW'(DEPTH) : '0;
    end
    if (IS_WR == ROLE_WR) begin
      flag_next   = (level_next == PW'(DEPTH));
      almost_next = (level_next >= PW'(DEPTH - ALMOST_TH));
    end else begin
      flag_next   = (level_next == '0);
      almost_next = (level_next <= PW'(ALMOST_TH));
    end
    // A fresh error outranks a simultaneous clear.
    err_next = (inc & flag) | corrupt | (err & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_bin  <= '0;
      ptr_gray <= '0;
      level    <= '0;
      flag     <= (IS_WR == ROLE_RD);
      almost   <= (IS_WR == ROLE_RD);
      err      <= 1'b0;
    end else begin
      ptr_bin  <= bin_next;
      ptr_gray <= gray_next;
      level    <= level_next;
      flag     <= flag_next;
      almost   <= almost_next;
      err      <= err_next;
    end
  end

endmodule
